ahb_spi_master_fifo: RTL and testbench

Parametrised AHB-Lite SPI master, successor to the single-buffer AHBspi peripheral. Adds TX/RX byte FIFOs, configurable slave-select count, all four SPI modes (CPOL/CPHA), a programmable SCLK divider, automatic slave-select, sticky overflow flags and an interrupt output. It sits on the AHB-Lite bus as a zero-wait-state slave and drives off-chip SPI slaves such as the Nexys4 display.

---
 rtl/ahb_spi_master_fifo.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ahb_spi_master_fifo.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_spi_master_fifo.sv
// AHB-Lite SPI master with TX/RX byte FIFOs, all four SPI modes,
// programmable SCLK divider, automatic slave-select and a level interrupt.

module ahb_spi_master_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the same cycle pops.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            if (do_push & ~do_pop) count <= count + (AW+1)'(1);
            else if (do_pop & ~do_push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

module ahb_spi_master_fifo #(
    parameter int NUM_SS     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic              HREADY,
    input  logic [31:0]       HADDR,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [1:0]        HTRANS,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    input  logic              SPI_MISO_i,
    output logic              SPI_MOSI_o,
    output logic [NUM_SS-1:0] SPI_SS_o,
    output logic              SPI_CLK_o,
    output logic              IRQ_o
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_SS     = 3'd1;
    localparam logic [2:0] A_TXDATA = 3'd2;
    localparam logic [2:0] A_RXDATA = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    logic              cpha;
    logic              cpol;
    logic              en;
    logic              ss_auto;
    logic [7:0]        clkdiv;
    logic              ie_txempty;
    logic              ie_rxavail;
    logic [NUM_SS-1:0] ss;
    logic              txovf;
    logic              rxovf;

    logic              dp_valid;
    logic              dp_write;
    logic [2:0]        dp_addr;
    logic              wr_en;
    logic              rd_en;

    logic              tx_push;
    logic              tx_pop;
    logic [7:0]        tx_dout;
    logic              tx_empty;
    logic              tx_full;
    logic              rx_push;
    logic              rx_pop;
    logic [7:0]        rx_dout;
    logic              rx_empty;
    logic              rx_full;

    state_t            state;
    state_t            state_n;
    logic [7:0]        tx_sh;
    logic [7:0]        rx_sh;
    logic              mosi;
    logic              sclk;
    logic              l_cpol;
    logic              l_cpha;
    logic [7:0]        l_div;
    logic [7:0]        div_cnt;
    logic [3:0]        half_cnt;
    logic              tick;
    logic              lead;
    logic              busy;
    logic              unused;

    assign unused = ^{HSIZE, HTRANS[0], HADDR, HWDATA};

    // Address phase is captured here; writes and pops land at the end of the
    // following data phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
        end else if (HREADY) begin
            dp_valid <= HSEL & HTRANS[1];
            dp_write <= HWRITE;
            dp_addr  <= HADDR[4:2];
        end
    end

    assign wr_en   = dp_valid & dp_write & HREADY;
    assign rd_en   = dp_valid & ~dp_write & HREADY;
    assign tx_push = wr_en & (dp_addr == A_TXDATA);
    assign tx_pop  = (state == LOAD);
    assign rx_push = (state == DONE);
    assign rx_pop  = rd_en & (dp_addr == A_RXDATA);

    ahb_spi_master_fifo_buf #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (tx_push),
        .din   (HWDATA[7:0]),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .empty (tx_empty),
        .full  (tx_full)
    );

    ahb_spi_master_fifo_buf #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (rx_push),
        .din   (rx_sh),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .empty (rx_empty),
        .full  (rx_full)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cpha       <= 1'b0;
            cpol       <= 1'b0;
            en         <= 1'b0;
            ss_auto    <= 1'b0;
            clkdiv     <= '0;
            ie_txempty <= 1'b0;
            ie_rxavail <= 1'b0;
            ss         <= '0;
            txovf      <= 1'b0;
            rxovf      <= 1'b0;
        end else begin
            if (wr_en && dp_addr == A_CTRL) begin
                cpha       <= HWDATA[0];
                cpol       <= HWDATA[1];
                en         <= HWDATA[2];
                ss_auto    <= HWDATA[3];
                clkdiv     <= HWDATA[15:8];
                ie_txempty <= HWDATA[16];
                ie_rxavail <= HWDATA[17];
            end
            if (wr_en && dp_addr == A_SS) ss <= HWDATA[NUM_SS-1:0];
            if (wr_en && dp_addr == A_STATUS && HWDATA[5]) txovf <= 1'b0;
            if (wr_en && dp_addr == A_STATUS && HWDATA[6]) rxovf <= 1'b0;
            // Setting a flag wins over a clear in the same cycle.
            if (tx_push & tx_full & ~tx_pop) txovf <= 1'b1;
            if (rx_push & rx_full & ~rx_pop) rxovf <= 1'b1;
        end
    end

    always_comb begin
        HRDATA = '0;
        if (dp_valid & ~dp_write) begin
            case (dp_addr)
                A_CTRL:   HRDATA = {14'b0, ie_rxavail, ie_txempty, clkdiv,
                                    4'b0, ss_auto, en, cpol, cpha};
                A_SS:     HRDATA = 32'(ss);
                A_RXDATA: HRDATA = rx_empty ? 32'b0 : {24'b0, rx_dout};
                A_STATUS: HRDATA = {25'b0, rxovf, txovf, busy, rx_full,
                                    rx_empty, tx_full, tx_empty};
                default:  HRDATA = '0;
            endcase
        end
    end

    assign tick = (div_cnt == l_div);
    assign lead = ~half_cnt[0];
    assign busy = (state != IDLE);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (en & ~tx_empty) state_n = LOAD;
            LOAD:    state_n = SHIFT;
            SHIFT:   if (tick && half_cnt == 4'd15) state_n = DONE;
            DONE:    state_n = (en & ~tx_empty) ? LOAD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            tx_sh    <= '0;
            rx_sh    <= '0;
            mosi     <= 1'b0;
            sclk     <= 1'b0;
            l_cpol   <= 1'b0;
            l_cpha   <= 1'b0;
            l_div    <= '0;
            div_cnt  <= '0;
            half_cnt <= '0;
        end else if (state == LOAD) begin
            tx_sh    <= tx_dout;
            l_cpol   <= cpol;
            l_cpha   <= cpha;
            l_div    <= clkdiv;
            div_cnt  <= '0;
            half_cnt <= '0;
            sclk     <= cpol;
            if (!cpha) mosi <= tx_dout[7];
        end else if (state == SHIFT) begin
            if (tick) begin
                div_cnt  <= '0;
                half_cnt <= half_cnt + 4'd1;
                sclk     <= ~sclk;
                // Sample edge is leading for CPHA=0, trailing for CPHA=1.
                if (lead ^ l_cpha) begin
                    rx_sh <= {rx_sh[6:0], SPI_MISO_i};
                end else if (l_cpha) begin
                    mosi  <= tx_sh[7];
                    tx_sh <= {tx_sh[6:0], 1'b0};
                end else begin
                    mosi  <= tx_sh[6];
                    tx_sh <= {tx_sh[6:0], 1'b0};
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

    assign SPI_CLK_o  = (state == SHIFT) ? sclk : cpol;
    assign SPI_MOSI_o = mosi;
    assign SPI_SS_o   = ss_auto ? ~(ss & {NUM_SS{busy}}) : ~ss;
    assign IRQ_o      = (ie_txempty & tx_empty & ~busy) |
                        (ie_rxavail & ~rx_empty);
    assign HREADYOUT  = 1'b1;
endmodule

// File: tb/tb_ahb_spi_master_fifo.sv
// Randomised bench for ahb_spi_master_fifo: bus reads are checked by a
// scoreboard monitor against a queue-based model of the FIFOs and engine.

module tb_ahb_spi_master_fifo;
    localparam int NSS   = 8;
    localparam int DEPTH = 8;

    logic              HCLK = 1'b0;
    logic              HRESET = 1'b1;
    logic              HSEL = 1'b0;
    logic              HREADY = 1'b1;
    logic [31:0]       HADDR = '0;
    logic              HWRITE = 1'b0;
    logic [2:0]        HSIZE = 3'b010;
    logic [1:0]        HTRANS = '0;
    logic [31:0]       HWDATA = '0;
    logic [31:0]       HRDATA;
    logic              HREADYOUT;
    logic              SPI_MISO_i;
    logic              SPI_MOSI_o;
    logic [NSS-1:0]    SPI_SS_o;
    logic              SPI_CLK_o;
    logic              IRQ_o;

    ahb_spi_master_fifo #(.NUM_SS(NSS), .FIFO_DEPTH(DEPTH)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HSEL       (HSEL),
        .HREADY     (HREADY),
        .HADDR      (HADDR),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HTRANS     (HTRANS),
        .HWDATA     (HWDATA),
        .HRDATA     (HRDATA),
        .HREADYOUT  (HREADYOUT),
        .SPI_MISO_i (SPI_MISO_i),
        .SPI_MOSI_o (SPI_MOSI_o),
        .SPI_SS_o   (SPI_SS_o),
        .SPI_CLK_o  (SPI_CLK_o),
        .IRQ_o      (IRQ_o)
    );

    always #5 HCLK = ~HCLK;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] pend_wdata = '0;

    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    bit          m_txovf = 0;
    bit          m_rxovf = 0;
    logic        loop = 1'b1;
    logic [7:0]  pat = 8'hA5;

    int          cyc = 0;
    bit          rd_dp = 0;
    int          rises = 0;
    int          first_edge = 0;
    bit          first_pending = 0;
    int          mosi_lead = 0;
    int          mosi_other = 0;
    int          ss_hi = 0;
    int          ss_lo = 0;
    int          ss_rise = 0;
    int          irq_bad = 0;
    logic        irq_at_rise = 1'b0;
    logic        t_cpol = 1'b0;
    logic        t_cpha = 1'b0;
    bit          slave_on = 0;
    int          se = 0;
    logic        slave_bit = 1'b0;

    assign SPI_MISO_i = loop ? SPI_MOSI_o : slave_bit;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a,
                              input logic [31:0] wd);
        HSEL = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HADDR = a;
        HWDATA = pend_wdata;
        @(posedge HCLK);
        #1;
        pend_wdata = wd;
    endtask

    task automatic bus_idle();
        HSEL = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HWDATA = pend_wdata;
        @(posedge HCLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_phase(1'b1, a, d);
        bus_idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e,
                      input string name);
        exp_q.push_back(e);
        tag_q.push_back(name);
        addr_phase(1'b0, a, '0);
        bus_idle();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    function automatic logic [31:0] exp_status();
        return {25'b0, m_rxovf, m_txovf, 1'b0,
                rx_q.size() == DEPTH, rx_q.size() == 0,
                tx_q.size() == DEPTH, tx_q.size() == 0};
    endfunction

    task automatic push_tx(input logic [7:0] b);
        if (tx_q.size() < DEPTH) tx_q.push_back(b);
        else m_txovf = 1;
        wr(32'h08, {24'b0, b});
    endtask

    task automatic m_run();
        logic [7:0] b;
        while (tx_q.size() > 0) begin
            b = tx_q.pop_front();
            if (rx_q.size() < DEPTH) rx_q.push_back(loop ? b : pat);
            else m_rxovf = 1;
        end
    endtask

    task automatic rd_rx(input string name);
        logic [31:0] e;
        e = (rx_q.size() > 0) ? {24'b0, rx_q.pop_front()} : 32'b0;
        rd(32'h0C, e, name);
    endtask

    task automatic m_reset();
        tx_q.delete();
        rx_q.delete();
        m_txovf = 0;
        m_rxovf = 0;
    endtask

    task automatic clr_mon();
        rises = 0;
        mosi_lead = 0;
        mosi_other = 0;
        ss_hi = 0;
        ss_lo = 0;
        ss_rise = 0;
        irq_bad = 0;
        irq_at_rise = 1'b0;
    endtask

    initial begin
        logic prev_clk;
        logic prev_mosi;
        logic prev_ss;
        logic chg;
        logic [7:0] b;
        logic [31:0] cw;
        int sidx;
        int div;
        int nb;
        int t_push;
        prev_clk = 1'b0;
        prev_mosi = 1'b0;
        prev_ss = 1'b1;

        fork
            forever begin
                @(posedge HCLK);
                cyc++;
                rd_dp = HSEL && HTRANS[1] && HREADY && !HWRITE && !HRESET;
            end
            forever begin
                @(negedge HCLK);
                if (rd_dp) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_read: got 0x%08h want none",
                                 HRDATA);
                    end else begin
                        chk(tag_q.pop_front(), HRDATA, exp_q.pop_front());
                    end
                end
                chg = (SPI_CLK_o != prev_clk);
                if (SPI_CLK_o && !prev_clk) rises++;
                if (chg && first_pending) begin
                    first_edge = cyc;
                    first_pending = 0;
                end
                if (SPI_MOSI_o != prev_mosi) begin
                    if (chg && SPI_CLK_o != t_cpol) mosi_lead++;
                    else mosi_other++;
                end
                if (SPI_SS_o[0]) ss_hi++;
                else ss_lo++;
                if (!SPI_SS_o[0] && IRQ_o) irq_bad++;
                if (SPI_SS_o[0] && !prev_ss) begin
                    ss_rise++;
                    irq_at_rise = IRQ_o;
                end
                if (!slave_on) se = 0;
                else if (chg) se = (se + 1) % 16;
                if (t_cpha) sidx = (se == 0) ? 0 : (se - 1) / 2;
                else sidx = se / 2;
                slave_bit = pat[7-sidx];
                prev_clk = SPI_CLK_o;
                prev_mosi = SPI_MOSI_o;
                prev_ss = SPI_SS_o[0];
            end
            begin
                #2000000;
                $display("FAIL watchdog: got timeout want finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset values
        wait_cyc(3);
        chk("rst_sclk", 32'(SPI_CLK_o), 0);
        chk("rst_mosi", 32'(SPI_MOSI_o), 0);
        chk("rst_ss", 32'(SPI_SS_o), 32'(8'hFF));
        chk("rst_irq", 32'(IRQ_o), 0);
        chk("rst_hreadyout", 32'(HREADYOUT), 1);
        HRESET = 1'b0;
        wait_cyc(2);
        rd(32'h10, exp_status(), "rst_status");
        rd(32'h00, 32'h0, "rst_ctrl");
        rd(32'h14, 32'h0, "unmapped_14");
        wr(32'h18, $urandom);
        rd(32'h00, 32'h0, "unmapped_wr_ignored");

        // Mode-0 loopback, CLKDIV=1
        loop = 1'b1;
        t_cpol = 1'b0;
        t_cpha = 1'b0;
        wr(32'h04, 32'h1);
        wr(32'h00, 32'h104);
        rd(32'h00, 32'h104, "ctrl_readback");
        clr_mon();
        first_pending = 1;
        tx_q.push_back(8'h13);
        addr_phase(1'b1, 32'h08, 32'h13);
        exp_q.push_back(exp_status());
        tag_q.push_back("b2b_status");
        addr_phase(1'b0, 32'h10, '0);
        t_push = cyc;
        bus_idle();
        push_tx(8'h08);
        wait_cyc(2 * 34 + 20);
        m_run();
        chk("tx_latency", 32'(first_edge - t_push), 4);
        chk("loop_rises", 32'(rises), 16);
        chk("loop_ss_held", 32'(ss_hi), 0);
        rd_rx("loop_rx0");
        rd_rx("loop_rx1");
        rd_rx("rx_empty_read");

        // Four modes against an external slave returning 0xA5
        for (int m = 0; m < 4; m++) begin
            div = $urandom_range(0, 2);
            t_cpha = m[0];
            t_cpol = m[1];
            cw = 32'h4 | 32'(m) | (32'(div) << 8);
            wr(32'h00, cw);
            wait_cyc(2);
            chk("sclk_idle_cpol", 32'(SPI_CLK_o), 32'(t_cpol));
            clr_mon();
            loop = 1'b0;
            slave_on = 1;
            push_tx(8'h96);
            wait_cyc(16 * (div + 1) + 12);
            m_run();
            chk("sclk_after_cpol", 32'(SPI_CLK_o), 32'(t_cpol));
            if (t_cpha) begin
                chk("mosi_off_lead", 32'(mosi_other), 0);
                chk("mosi_on_lead", 32'(mosi_lead >= 5), 1);
            end
            rd_rx("mode_rx_a5");
            slave_on = 0;
            loop = 1'b1;
        end

        // Random loopback traffic
        for (int it = 0; it < 10; it++) begin
            div = $urandom_range(0, 3);
            nb = $urandom_range(1, 3);
            cw = 32'($urandom_range(0, 3));
            t_cpol = cw[1];
            t_cpha = cw[0];
            wr(32'h00, 32'h4 | cw | (32'(div) << 8));
            for (int k = 0; k < nb; k++) begin
                b = 8'($urandom);
                push_tx(b);
            end
            wait_cyc(nb * (16 * (div + 1) + 2) + 12);
            m_run();
            for (int k = 0; k < nb; k++) rd_rx("rand_rx");
        end

        // TX overflow with engine disabled
        wr(32'h00, 32'h0);
        t_cpol = 1'b0;
        t_cpha = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) push_tx(8'($urandom));
        rd(32'h10, exp_status(), "txovf_status");
        wr(32'h10, 32'h20);
        m_txovf = 0;
        rd(32'h10, exp_status(), "txovf_cleared");
        clr_mon();
        wr(32'h00, 32'h4);
        wait_cyc(DEPTH * 18 + 20);
        m_run();
        chk("depth_rises", 32'(rises), 32'(DEPTH * 8));
        rd(32'h10, exp_status(), "rxfull_status");

        // RX overflow
        push_tx(8'($urandom));
        push_tx(8'($urandom));
        wait_cyc(2 * 18 + 20);
        m_run();
        rd(32'h10, exp_status(), "rxovf_status");
        for (int k = 0; k < DEPTH; k++) rd_rx("rx_retained");
        rd_rx("rx_empty_after");
        rd(32'h10, exp_status(), "rxovf_sticky");
        wr(32'h10, 32'h40);
        m_rxovf = 0;
        rd(32'h10, exp_status(), "rxovf_cleared");

        // Auto slave-select and interrupts
        wr(32'h00, 32'h1000C);
        wait_cyc(2);
        chk("auto_ss_idle", 32'(SPI_SS_o[0]), 1);
        chk("irq_idle_txempty", 32'(IRQ_o), 1);
        clr_mon();
        push_tx(8'($urandom));
        wait_cyc(40);
        m_run();
        chk("auto_ss_low_cycles", 32'(ss_lo), 18);
        chk("auto_ss_rises", 32'(ss_rise), 1);
        chk("irq_while_busy", 32'(irq_bad), 0);
        chk("irq_at_idle", 32'(irq_at_rise), 1);
        wr(32'h00, 32'h20004);
        wait_cyc(1);
        chk("irq_rxavail", 32'(IRQ_o), 1);
        rd_rx("irq_rx");
        chk("irq_rx_cleared", 32'(IRQ_o), 0);

        // Reset in mid-byte
        wr(32'h00, 32'h10307);
        push_tx(8'($urandom));
        wait_cyc(20);
        @(negedge HCLK);
        HRESET = 1'b1;
        #1;
        chk("mid_rst_sclk", 32'(SPI_CLK_o), 0);
        chk("mid_rst_mosi", 32'(SPI_MOSI_o), 0);
        chk("mid_rst_ss", 32'(SPI_SS_o), 32'(8'hFF));
        chk("mid_rst_hrdata", HRDATA, 0);
        chk("mid_rst_irq", 32'(IRQ_o), 0);
        chk("mid_rst_hreadyout", 32'(HREADYOUT), 1);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        m_reset();
        t_cpol = 1'b0;
        t_cpha = 1'b0;
        rd(32'h10, exp_status(), "mid_rst_status");
        rd(32'h00, 32'h0, "mid_rst_ctrl");
        wait_cyc(80);
        rd(32'h10, exp_status(), "mid_rst_no_push");

        wait_cyc(4);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
